lcv_mul_acc_seq: RTL
====================

Name: lcv_mul_acc_seq

Overview:
- Sequential 32x32 -> 64-bit multiply-accumulate unit.
- Breaks each operand into 16-bit halves and issues one 17x17 signed partial product per cycle into a registered product stage, then a 64-bit accumulator stage. This is the same two-register structure the team's DSP-mapped multiply-accumulate cells use.
- Sits between the ALU issue logic and writeback. Uses a valid/ready handshake on both sides.

Parameters:
- HALF_WIDTH, default 16: operand half width. Operand width is 2*HALF_WIDTH; result width is 4*HALF_WIDTH.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; synchronous, active-low (asserted when 0).
- inp_valid  input  1  request valid.
- inp_ready  output  1  unit can accept a request.
- inp_a  input  2*HALF_WIDTH  multiplicand.
- inp_b  input  2*HALF_WIDTH  multiplier.
- inp_signed  input  1  1 = signed x signed, 0 = unsigned x unsigned.
- inp_acc_en  input  1  1 = add inp_acc to the product.
- inp_acc  input  4*HALF_WIDTH  accumulate addend (two's complement or unsigned; mod 2^64).
- outp_valid  output  1  result valid.
- outp_ready  input  1  consumer accepts the result.
- outp_data  output  4*HALF_WIDTH  (a*b + (acc_en ? acc : 0)) mod 2^(4*HALF_WIDTH).

Behaviour:
- Reset (rst==0 at posedge) applies regardless of state, including mid-operation; any in-flight result is discarded.
  - state=IDLE, step=0, product reg=0, accumulator=0.
  - inp_ready=0 during the reset cycle, then 1 in IDLE.
  - outp_valid=0, outp_data=0.
- Accept: at a posedge with state==IDLE, inp_valid==1 and inp_ready==1 (cycle T):
  - capture a, b and signed;
  - accumulator <= inp_acc_en ? inp_acc : 0;
  - state <= ISSUE, step <= 0.
- inp_ready = (state==IDLE), purely from registered state; no combinational path from inp_valid or outp_ready.
- Half extension to 17 bits:
  - low half = {0, x[15:0]};
  - high half = {signed ? x[31] : 0, x[31:16]}.
- Step schedule, one partial product per cycle, with shift:
  - step 0: aL*bL, shift 0;
  - step 1: aL*bH, shift 16;
  - step 2: aH*bL, shift 16;
  - step 3: aH*bH, shift 32.
- Product stage: each ISSUE edge registers the 34-bit signed product and its shift code, and sets pp_valid.
- Accumulate stage: on each edge where pp_valid==1, accumulator <= accumulator + (sign-extended product << shift), truncated to 64 bits.
- FSM:
  - IDLE -> ISSUE on accept.
  - ISSUE: step increments each edge; after step 3 -> DRAIN.
  - DRAIN: one edge, final accumulate, -> DONE.
  - DONE: outp_valid=1; outp_data = accumulator, held stable until handshake.
  - DONE -> IDLE at a posedge with outp_ready==1.
- Latency:
  - product-register edges T+1..T+4; accumulate edges T+2..T+5; DONE entered at edge T+5;
  - outp_valid first observable in the cycle after edge T+5;
  - minimum initiation interval 7 cycles (no overlap).
- Back-pressure: outp_ready==0 keeps the unit in DONE indefinitely with outp_valid and outp_data unchanged. inp_valid is ignored outside IDLE.
- Dropping outp_valid: it drops at the posedge consuming the result. inp_ready rises in the same cycle.
- outp_data after consumption: retains the last result until the next DONE entry (not cleared). Reads 0 only after reset.
- inp_* values are sampled only at the accept edge. Changes while busy have no effect.

Test Plan:
- Unsigned max: a=0xFFFFFFFF, b=0xFFFFFFFF, signed=0, acc_en=0 -> outp_data=0xFFFFFFFE00000001, outp_valid in the cycle after edge T+5.
- Signed extremes:
  - a=0x80000000, b=0x80000000, signed=1 -> 0x4000000000000000;
  - a=0xFFFFFFFF, b=0xFFFFFFFF, signed=1 -> 0x0000000000000001.
- Accumulate: a=-3, b=5, signed=1, acc_en=1, acc=20 -> 0x0000000000000005. Second request with acc_en=0, acc=0x1234 -> result -15 (0xFFFFFFFFFFFFFFF1); acc ignored.
- Back-pressure: hold outp_ready=0 for 10 cycles after outp_valid -> outp_valid and outp_data stable, inp_ready=0. inp_valid pulses meanwhile are ignored; after the outp_ready pulse, inp_ready=1 in the next cycle.
- Reset mid-op: assert rst=0 at edge T+3 of a request -> next cycle outp_valid=0, outp_data=0, inp_ready=0. After rst=1, inp_ready=1 and a fresh request 7*9 returns 63 with correct latency.
- Back-to-back: drive inp_valid constantly with outp_ready=1 -> accepts every 7 cycles. 100 random signed/unsigned/acc requests match the reference model mod 2^64.

Source files
------------

// File: rtl/lcv_mul_acc_seq.sv
// Sequential 2H x 2H -> 4H multiply-accumulate: one (H+1)x(H+1) signed partial
// product per cycle into a product register, then a 4H-bit accumulator register.
module lcv_mul_acc_seq #(
  parameter int HALF_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inp_valid,
  output logic                    inp_ready,
  input  logic [2*HALF_WIDTH-1:0] inp_a,
  input  logic [2*HALF_WIDTH-1:0] inp_b,
  input  logic                    inp_signed,
  input  logic                    inp_acc_en,
  input  logic [4*HALF_WIDTH-1:0] inp_acc,
  output logic                    outp_valid,
  input  logic                    outp_ready,
  output logic [4*HALF_WIDTH-1:0] outp_data
);

  localparam int H = HALF_WIDTH;
  localparam int W = 2 * H;
  localparam int R = 4 * H;
  localparam int P = 2 * H + 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                r_live;
  logic [1:0]          r_step;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic                r_signed;
  logic signed [P-1:0] r_pp;
  logic [1:0]          r_shift;
  logic                r_pp_valid;
  logic [R-1:0]        r_acc;
  logic [R-1:0]        r_result;

  logic                w_accept;
  logic [H:0]          w_a_lo, w_a_hi, w_b_lo, w_b_hi;
  logic signed [H:0]   w_op_a, w_op_b;
  logic [1:0]          w_shift;
  logic signed [P-1:0] w_prod;
  logic [R-1:0]        w_pp_ext;
  logic [R-1:0]        w_addend;
  logic [R-1:0]        w_acc_sum;

  // r_live holds inp_ready low for the cycle that follows a reset edge.
  assign inp_ready  = r_live && (r_state == S_IDLE);
  assign w_accept   = inp_ready && inp_valid;
  assign outp_valid = (r_state == S_DONE);
  assign outp_data  = r_result;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!rst) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_live  <= 1'b1;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_next = S_ISSUE;
      S_ISSUE: if (r_step == 2'd3) w_state_next = S_DRAIN;
      S_DRAIN: w_state_next = S_DONE;
      S_DONE:  if (outp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Low halves are always unsigned; high halves carry the sign in signed mode.
  assign w_a_lo = {1'b0, r_a[H-1:0]};
  assign w_b_lo = {1'b0, r_b[H-1:0]};
  assign w_a_hi = {r_signed & r_a[W-1], r_a[W-1:H]};
  assign w_b_hi = {r_signed & r_b[W-1], r_b[W-1:H]};

  always_comb begin
    w_op_a  = w_a_lo;
    w_op_b  = w_b_lo;
    w_shift = 2'd0;
    case (r_step)
      2'd1: begin w_op_b = w_b_hi; w_shift = 2'd1; end
      2'd2: begin w_op_a = w_a_hi; w_shift = 2'd1; end
      2'd3: begin w_op_a = w_a_hi; w_op_b = w_b_hi; w_shift = 2'd2; end
      default: ;
    endcase
  end

  assign w_prod   = w_op_a * w_op_b;
  assign w_pp_ext = {{(R-P){r_pp[P-1]}}, r_pp};

  always_comb begin
    w_addend = w_pp_ext;
    case (r_shift)
      2'd1:    w_addend = w_pp_ext << H;
      2'd2:    w_addend = w_pp_ext << (2 * H);
      default: ;
    endcase
  end

  assign w_acc_sum = r_acc + w_addend;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_step     <= 2'd0;
      r_a        <= '0;
      r_b        <= '0;
      r_signed   <= 1'b0;
      r_pp       <= '0;
      r_shift    <= 2'd0;
      r_pp_valid <= 1'b0;
      r_acc      <= '0;
      r_result   <= '0;
    end else begin
      r_pp_valid <= (r_state == S_ISSUE);
      if (r_state == S_ISSUE) begin
        r_pp    <= w_prod;
        r_shift <= w_shift;
        r_step  <= r_step + 2'd1;
      end
      if (w_accept) begin
        r_a      <= inp_a;
        r_b      <= inp_b;
        r_signed <= inp_signed;
        r_step   <= 2'd0;
        r_acc    <= inp_acc_en ? inp_acc : '0;
      end else if (r_pp_valid) begin
        r_acc <= w_acc_sum;
      end
      // The result register keeps the last answer after the accumulator is reloaded.
      if (r_state == S_DRAIN) r_result <= w_acc_sum;
    end
  end

endmodule
